capture_buf_reader: RTL and testbench
=====================================

Name: capture_buf_reader

Overview:
- Read-side counterpart of the capture controller: after a measurement finishes, reads the captured samples out of the capture BRAM and streams them to firmware over a valid/ready interface.
- Drives the BRAM read port, absorbs the fixed BRAM read latency with an internal credit-controlled buffer, and marks the last word.
- Reports completion and misuse events to firmware.

Parameters:
- FIFO_SIZE, 1024: capture buffer depth in words.
- FIFO_SIZE_WIDTH, $clog2(FIFO_SIZE)+1: width of the word count. The read address is FIFO_SIZE_WIDTH-1 bits.
- DATA_WIDTH, 32: sample width.
- RD_LATENCY, 2: BRAM read latency in cycles, from rd_en to valid rd_data. Legal values are 1..3.
- OUT_DEPTH, RD_LATENCY+1: output buffer depth in words.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start_read  in  1  one-cycle request from firmware to start a readout.
- data_count  in  FIFO_SIZE_WIDTH  number of valid words in the BRAM. Sampled at start.
- rd_en  out  1  BRAM read enable.
- rd_addr  out  FIFO_SIZE_WIDTH-1  BRAM read address.
- rd_data  in  DATA_WIDTH  BRAM read data, valid RD_LATENCY cycles after rd_en.
- m_data  out  DATA_WIDTH  output word.
- m_valid  out  1  output word valid.
- m_ready  in  1  firmware ready.
- m_last  out  1  qualifies the final word.
- busy  out  1  readout in progress.
- read_done  out  1  one-cycle completion pulse.
- event_start_read_when_busy  out  1  one-cycle pulse.
- event_start_read_when_empty  out  1  one-cycle pulse.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state to IDLE;
  - every output to 0, including rd_addr, m_data and all event outputs;
  - issue counter, in-flight shift register and output buffer to empty.
- Reset mid-readout discards all in-flight and buffered words. No read_done is produced.
- States:
  - IDLE: on start_read with data_count != 0, latch len = min(data_count, FIFO_SIZE) and go to ISSUE.
  - ISSUE: issue reads until len reads have been issued, then go to DRAIN.
  - DRAIN: wait until in-flight = 0 and the buffer is empty after the last pop, then go to DONE.
  - DONE: assert read_done for one cycle, then return to IDLE.
- busy is 1 in ISSUE, DRAIN and DONE.
- start_read in IDLE with data_count == 0: stay in IDLE and pulse event_start_read_when_empty in the next cycle.
- start_read in any state other than IDLE: ignored; pulse event_start_read_when_busy in the next cycle.
- Issue rule:
  - rd_en = (state == ISSUE) && (issued < len) && (inflight + occ - pop < OUT_DEPTH).
  - pop = m_valid && m_ready.
  - This rule never overflows the output buffer and sustains 1 word/cycle while m_ready = 1.
- Addressing:
  - rd_addr is 0 for the first read and increments by 1 after each rd_en.
  - Last address is len-1. rd_addr never wraps.
  - rd_addr returns to 0 in IDLE.
- In-flight tracking: an RD_LATENCY-deep shift register of rd_en. Its output writes rd_data into the output buffer.
- Output buffer:
  - OUT_DEPTH-entry show-ahead FIFO; m_data is its head.
  - m_valid = buffer not empty.
  - A simultaneous push and pop is legal, including at full.
- Latency: start_read sampled in cycle T gives:
  - first rd_en in cycle T+1;
  - first m_valid in cycle T+2+RD_LATENCY.
- m_last is 1 exactly while the head word is word index len-1.
- Handshake: once m_valid is high, it stays high and m_data stays stable until m_ready is seen.
- m_ready held at 0: reads stall once inflight + occ reaches OUT_DEPTH. No data is lost.
- len = FIFO_SIZE (full capture): last rd_addr is FIFO_SIZE-1 and the address register does not overflow.
- data_count > FIFO_SIZE: clamped to FIFO_SIZE.

Optional Feature:
- Macro: CAPTURE_BUF_READER_CHECKSUM_EN.
- When defined:
  - adds output checksum [DATA_WIDTH-1:0], a modulo-2^DATA_WIDTH sum of every popped word;
  - checksum clears on the accepted start_read;
  - checksum is stable and valid from the cycle read_done is high until the next accepted start_read;
  - reset value is 0.
- When undefined: no port and no logic.

Decomposition:
- Shared package: state encodings (IDLE=0, ISSUE=1, DRAIN=2, DONE=3) and the $clog2-derived width constants.
- The width constants are shared with the capture controller.
- One sub-module: capture_out_fifo. It is a parameterised show-ahead FIFO (DEPTH, DATA_WIDTH) with push, pop, occ, empty and full.

Test Plan:
1. data_count=8, m_ready=1, RD_LATENCY=2 -> rd_addr 0..7 on cycles T+1..T+8; m_valid from T+4; 8 words equal to BRAM contents; m_last only on word 7; read_done once, 2 cycles after the last pop.
2. data_count=16, m_ready toggled randomly -> all 16 words in order; no data change while m_valid=1 and m_ready=0; inflight+occ never exceeds 3.
3. data_count=0 with start_read -> event_start_read_when_empty pulses once; busy stays 0; no rd_en.
4. start_read again at word 5 of 10 -> event_start_read_when_busy pulses once; the readout completes unaffected with 10 words.
5. data_count=1024, m_ready=1 -> 1024 words at 1 word/cycle; last rd_addr=1023; m_last on word 1023. With data_count=1100, only 1024 words are read.
6. rst asserted at word 3 of 10 -> all outputs 0 immediately, state IDLE, no read_done. A fresh start_read with data_count=4 then reads words 0..3 cleanly.

Source files
------------

// File: rtl/capture_buf_reader_pkg.sv
// Shared definitions for the capture buffer reader and the capture controller:
// readout state encoding and the buffer-size-derived width constants.
package capture_buf_reader_pkg;

    localparam int CAP_FIFO_SIZE       = 1024;
    localparam int CAP_FIFO_SIZE_WIDTH = $clog2(CAP_FIFO_SIZE) + 1;
    localparam int CAP_ADDR_WIDTH      = CAP_FIFO_SIZE_WIDTH - 1;
    localparam int CAP_DATA_WIDTH      = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/capture_buf_reader_if.sv
// BRAM read port plus the valid/ready output stream of the capture buffer reader.
// The master side is the reader; the slave side is the BRAM and firmware.
interface capture_buf_reader_if
    import capture_buf_reader_pkg::*;
#(
    parameter int DATA_WIDTH = CAP_DATA_WIDTH,
    parameter int ADDR_WIDTH = CAP_ADDR_WIDTH
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (
        output rd_en, rd_addr, m_data, m_valid, m_last,
        input  rd_data, m_ready
    );

    modport slave (
        input  rd_en, rd_addr, m_data, m_valid, m_last,
        output rd_data, m_ready
    );
endinterface

// File: rtl/capture_buf_reader_out_fifo.sv
// Small show-ahead FIFO that absorbs the BRAM read latency; head is the oldest word.
// A push and pop in the same cycle is accepted even when the FIFO is full.
module capture_out_fifo #(
    parameter int DEPTH      = 3,
    parameter int DATA_WIDTH = 32,
    parameter int OCC_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [OCC_W-1:0]      occ,
    output logic                  empty,
    output logic                  full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      wptr_r;
    logic [PTR_W-1:0]      rptr_r;
    logic [OCC_W-1:0]      occ_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign do_pop_s  = pop && (occ_r != {OCC_W{1'b0}});
    assign do_push_s = push && ((occ_r != OCC_W'(DEPTH)) || do_pop_s);

    // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r <= {PTR_W{1'b0}};
            rptr_r <= {PTR_W{1'b0}};
            occ_r  <= {OCC_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wptr_r] <= push_data;
                wptr_r        <= ptr_inc(wptr_r);
            end
            if (do_pop_s) begin
                rptr_r <= ptr_inc(rptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign head  = mem_r[rptr_r];
    assign occ   = occ_r;
    assign empty = (occ_r == {OCC_W{1'b0}});
    assign full  = (occ_r == OCC_W'(DEPTH));
endmodule

// File: rtl/capture_buf_reader.sv
// Streams captured samples out of the capture BRAM with credit-limited read issue.
// Optional checksum output: define CAPTURE_BUF_READER_CHECKSUM_EN.
module capture_buf_reader
    import capture_buf_reader_pkg::*;
#(
    parameter int FIFO_SIZE       = CAP_FIFO_SIZE,
    parameter int FIFO_SIZE_WIDTH = $clog2(FIFO_SIZE) + 1,
    parameter int DATA_WIDTH      = CAP_DATA_WIDTH,
    parameter int RD_LATENCY      = 2,
    parameter int OUT_DEPTH       = RD_LATENCY + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    capture_buf_reader_if.master       bus,
    input  logic                       start_read,
    input  logic [FIFO_SIZE_WIDTH-1:0] data_count,
    output logic                       busy,
    output logic                       read_done,
    output logic                       event_start_read_when_busy,
    output logic                       event_start_read_when_empty
`ifdef CAPTURE_BUF_READER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]      checksum
`endif
);
    localparam int AW    = FIFO_SIZE_WIDTH - 1;
    localparam int OCC_W = $clog2(OUT_DEPTH + 1);
    localparam int CNT_W = 4;

    rd_state_e                  state_r;
    rd_state_e                  state_s;
    logic [FIFO_SIZE_WIDTH-1:0] len_r;
    logic [FIFO_SIZE_WIDTH-1:0] issued_r;
    logic [FIFO_SIZE_WIDTH-1:0] popped_r;
    logic [FIFO_SIZE_WIDTH-1:0] clamped_len_s;
    logic [AW-1:0]              rd_addr_r;
    logic [RD_LATENCY-1:0]      inflight_sr_r;
    logic [CNT_W-1:0]           inflight_s;
    logic [OCC_W-1:0]           occ_s;
    logic [DATA_WIDTH-1:0]      head_s;
    logic                       empty_s;
    logic                       full_s;
    logic                       pop_s;
    logic                       rd_en_s;
    logic                       accept_s;
    logic                       ev_busy_r;
    logic                       ev_empty_r;

    assign accept_s      = (state_r == ST_IDLE) && start_read && (data_count != {FIFO_SIZE_WIDTH{1'b0}});
    assign clamped_len_s = (data_count > FIFO_SIZE_WIDTH'(FIFO_SIZE)) ? FIFO_SIZE_WIDTH'(FIFO_SIZE) : data_count;
    assign pop_s         = !empty_s && bus.m_ready;

    // Count reads that have been issued but whose data has not yet reached the buffer.
    always_comb begin
        inflight_s = {CNT_W{1'b0}};
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_s = inflight_s + CNT_W'(inflight_sr_r[i]);
        end
    end

    // A read is issued only when its word is guaranteed a buffer slot on arrival.
    assign rd_en_s = (state_r == ST_ISSUE) && (issued_r < len_r)
                     && ((inflight_s + CNT_W'(occ_s)) < (CNT_W'(OUT_DEPTH) + CNT_W'(pop_s)))
                     && !(full_s && !pop_s);

    // Readout sequencing.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (rd_en_s && ((issued_r + FIFO_SIZE_WIDTH'(1)) == len_r)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if ((inflight_s == {CNT_W{1'b0}}) && empty_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, counters, address, latency pipe and misuse pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            len_r         <= {FIFO_SIZE_WIDTH{1'b0}};
            issued_r      <= {FIFO_SIZE_WIDTH{1'b0}};
            popped_r      <= {FIFO_SIZE_WIDTH{1'b0}};
            rd_addr_r     <= {AW{1'b0}};
            inflight_sr_r <= {RD_LATENCY{1'b0}};
            ev_busy_r     <= 1'b0;
            ev_empty_r    <= 1'b0;
        end else begin
            state_r       <= state_s;
            inflight_sr_r <= (inflight_sr_r << 1) | RD_LATENCY'(rd_en_s);
            ev_busy_r     <= start_read && (state_r != ST_IDLE);
            ev_empty_r    <= start_read && (state_r == ST_IDLE) && (data_count == {FIFO_SIZE_WIDTH{1'b0}});
            if (accept_s) begin
                len_r    <= clamped_len_s;
                issued_r <= {FIFO_SIZE_WIDTH{1'b0}};
                popped_r <= {FIFO_SIZE_WIDTH{1'b0}};
            end else begin
                if (rd_en_s) begin
                    issued_r <= issued_r + FIFO_SIZE_WIDTH'(1);
                end
                if (pop_s) begin
                    popped_r <= popped_r + FIFO_SIZE_WIDTH'(1);
                end
            end
            // Hold at len-1 after the final read so a full-size capture never wraps.
            if (state_r == ST_IDLE) begin
                rd_addr_r <= {AW{1'b0}};
            end else if (rd_en_s && ((issued_r + FIFO_SIZE_WIDTH'(1)) < len_r)) begin
                rd_addr_r <= rd_addr_r + AW'(1);
            end
        end
    end

    capture_out_fifo #(
        .DEPTH      (OUT_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .OCC_W      (OCC_W)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_sr_r[RD_LATENCY-1]),
        .push_data (bus.rd_data),
        .pop       (pop_s),
        .head      (head_s),
        .occ       (occ_s),
        .empty     (empty_s),
        .full      (full_s)
    );

`ifdef CAPTURE_BUF_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_r;

    // Running modulo-2^DATA_WIDTH sum of every word handed to firmware.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_r <= {DATA_WIDTH{1'b0}};
        end else if (accept_s) begin
            checksum_r <= {DATA_WIDTH{1'b0}};
        end else if (pop_s) begin
            checksum_r <= checksum_r + head_s;
        end
    end

    assign checksum = checksum_r;
`endif

    assign bus.rd_en                   = rd_en_s;
    assign bus.rd_addr                 = rd_addr_r;
    assign bus.m_data                  = head_s;
    assign bus.m_valid                 = !empty_s;
    assign bus.m_last                  = !empty_s && (popped_r == (len_r - FIFO_SIZE_WIDTH'(1)));
    assign busy                        = (state_r != ST_IDLE);
    assign read_done                   = (state_r == ST_DONE);
    assign event_start_read_when_busy  = ev_busy_r;
    assign event_start_read_when_empty = ev_empty_r;
endmodule

// File: tb/tb_capture_buf_reader.sv
// Scoreboard bench for capture_buf_reader: randomized BRAM contents and m_ready,
// expected words queued at each accepted start and checked by a negedge monitor.
module tb_capture_buf_reader;
    localparam int FS  = 1024;
    localparam int FSW = 11;
    localparam int DW  = 32;
    localparam int RL  = 2;
    localparam int OD  = RL + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start_read = 1'b0;
    logic [FSW-1:0] data_count = '0;
    logic           busy, read_done, ev_busy, ev_empty;
`ifdef CAPTURE_BUF_READER_CHECKSUM_EN
    logic [DW-1:0]  checksum;
`endif

    capture_buf_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(FSW-1)) bus();

    capture_buf_reader #(
        .FIFO_SIZE(FS), .FIFO_SIZE_WIDTH(FSW), .DATA_WIDTH(DW), .RD_LATENCY(RL), .OUT_DEPTH(OD)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .bus                         (bus),
        .start_read                  (start_read),
        .data_count                  (data_count),
        .busy                        (busy),
        .read_done                   (read_done),
        .event_start_read_when_busy  (ev_busy),
        .event_start_read_when_empty (ev_empty)
`ifdef CAPTURE_BUF_READER_CHECKSUM_EN
        ,
        .checksum                    (checksum)
`endif
    );

    always #5 clk = ~clk;

    // BRAM model with RL-cycle read latency
    logic [DW-1:0] bram [FS];
    logic [DW-1:0] pipe [RL];
    always @(posedge clk) begin
        pipe[0] <= bus.rd_en ? bram[bus.rd_addr] : 32'hDEAD_BEEF;
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.rd_data = pipe[RL-1];

    int checks = 0, errors = 0, cyc = 0;
    logic [DW-1:0] exp_data_q [$];
    bit            exp_last_q [$];
    bit            active = 1'b0, first_valid_seen = 1'b0, prev_hold = 1'b0, ready_mode = 1'b0;
    logic [DW-1:0] prev_data = '0, csum_exp = '0;
    int start_cyc = 0, req_cyc = 0, rd_cnt = 0, pop_cnt = 0, cur_len = 0;
    int first_rd_cyc = 0, last_rd_cyc = 0, first_pop_cyc = 0, last_pop_cyc = 0;
    int done_cnt = 0, exp_done = 0, ev_busy_cnt = 0, exp_ev_busy = 0, ev_empty_cnt = 0, exp_ev_empty = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.m_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks protocol timing
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) check("hold_stable", {bus.m_valid, bus.m_data}, {1'b1, prev_data});
            if (bus.rd_en) begin
                if (rd_cnt == 0) begin
                    check("first_rd_latency", cyc, start_cyc + 1);
                    first_rd_cyc = cyc;
                end
                check("rd_addr", bus.rd_addr, rd_cnt);
                last_rd_cyc = cyc;
                rd_cnt++;
                check("outstanding_le_depth",
                      (rd_cnt - pop_cnt - ((bus.m_valid && bus.m_ready) ? 1 : 0)) <= OD, 1);
            end
            if (bus.m_valid && active && !first_valid_seen) begin
                check("first_valid_latency", cyc, start_cyc + 2 + RL);
                first_valid_seen = 1'b1;
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_data_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word actual=%0h expected=none", bus.m_data);
                end else begin
                    check("m_data", bus.m_data, exp_data_q.pop_front());
                    check("m_last", bus.m_last, exp_last_q.pop_front());
                end
                if (pop_cnt == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                pop_cnt++;
            end
            if (read_done) begin
                check("done_while_active", active, 1);
                check("done_all_words", exp_data_q.size(), 0);
                check("done_timing", cyc, last_pop_cyc + 2);
`ifdef CAPTURE_BUF_READER_CHECKSUM_EN
                check("checksum", checksum, csum_exp);
`endif
                done_cnt++;
                active = 1'b0;
            end
            if (ev_busy) begin
                ev_busy_cnt++;
                check("ev_busy_timing", cyc, req_cyc + 1);
            end
            if (ev_empty) begin
                ev_empty_cnt++;
                check("ev_empty_timing", cyc, req_cyc + 1);
            end
            prev_hold = bus.m_valid && !bus.m_ready;
            prev_data = bus.m_data;
        end
    end

    task automatic start_req(input int count);
        int len;
        @(posedge clk); #1;
        data_count = count[FSW-1:0];
        start_read = 1'b1;
        req_cyc = cyc;
        if (active) begin
            exp_ev_busy++;
        end else if (count == 0) begin
            exp_ev_empty++;
        end else begin
            len = (count > FS) ? FS : count;
            cur_len = len; rd_cnt = 0; pop_cnt = 0; first_valid_seen = 1'b0; csum_exp = '0;
            for (int i = 0; i < len; i++) begin
                exp_data_q.push_back(bram[i]);
                exp_last_q.push_back(i == len - 1);
                csum_exp = csum_exp + bram[i];
            end
            start_cyc = cyc; active = 1'b1; exp_done++;
        end
        @(posedge clk); #1;
        start_read = 1'b0;
        data_count = FSW'($urandom);
    endtask

    task automatic wait_done(input int budget, input bit full_rate);
        for (int i = 0; i < budget && active; i++) @(posedge clk);
        if (active) begin
            checks++; errors++;
            $display("FAIL readout_timeout actual=busy expected=done len=%0d", cur_len);
            active = 1'b0;
            exp_data_q.delete(); exp_last_q.delete();
        end
        check("rd_count", rd_cnt, cur_len);
        if (full_rate) begin
            check("rd_rate", last_rd_cyc - first_rd_cyc, cur_len - 1);
            check("pop_rate", last_pop_cyc - first_pop_cyc, cur_len - 1);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {busy, read_done, ev_busy, ev_empty, bus.rd_en, bus.m_valid, bus.m_last}, 0);
        check({tag, "_rd_addr"}, bus.rd_addr, 0);
        check({tag, "_m_data"}, bus.m_data, 0);
`ifdef CAPTURE_BUF_READER_CHECKSUM_EN
        check({tag, "_checksum"}, checksum, 0);
`endif
    endtask

    initial begin
        for (int i = 0; i < FS; i++) bram[i] = $urandom;
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset");
        rst = 1'b0;

        // Full-rate readout of 8 words
        ready_mode = 1'b0;
        start_req(8);
        check("busy_after_start", busy, 1);
        wait_done(200, 1'b1);

        // Back-pressured readout of 16 words
        ready_mode = 1'b1;
        start_req(16);
        wait_done(500, 1'b0);

        // Start with nothing captured
        start_req(0);
        for (int i = 0; i < 5; i++) begin
            check("empty_no_activity", {busy, bus.rd_en}, 0);
            @(posedge clk); #1;
        end

        // Second start while a 10-word readout is running
        start_req(10);
        for (int g = 0; g < 500 && pop_cnt < 5; g++) @(posedge clk);
        start_req(7);
        wait_done(500, 1'b0);
        check("busy_start_len_kept", cur_len, 10);

        // Full capture and over-range count
        ready_mode = 1'b0;
        start_req(FS);
        wait_done(3000, 1'b1);
        start_req(1100);
        wait_done(3000, 1'b1);

        // Random lengths with random back-pressure
        ready_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            start_req($urandom_range(1, 40));
            wait_done(1000, 1'b0);
        end

        // Reset in the middle of a readout, then a clean restart
        ready_mode = 1'b0;
        start_req(10);
        for (int g = 0; g < 200 && pop_cnt < 3; g++) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_outputs_zero("midreset");
        active = 1'b0; exp_done--;
        exp_data_q.delete(); exp_last_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        start_req(4);
        wait_done(200, 1'b1);

        repeat (5) @(posedge clk);
        check("done_count", done_cnt, exp_done);
        check("ev_busy_count", ev_busy_cnt, exp_ev_busy);
        check("ev_empty_count", ev_empty_cnt, exp_ev_empty);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end
endmodule
